// File: rtl/channel_strip_pkg.sv
// Shared types and constants for the channel-strip blocks.
package channel_strip_pkg;

  localparam int CLKS_PER_SAMPLE = 3;

  typedef logic signed [15:0] sample_t;
  typedef logic [2:0]         filt_sel_t;

  typedef enum logic [1:0] {
    SW_IDLE     = 2'd0,
    SW_FADE_OUT = 2'd1,
    SW_CLEAR    = 2'd2,
    SW_FADE_IN  = 2'd3
  } sw_state_t;

endpackage

// File: rtl/filter_switch_ctrl_if.sv
// Control/datapath bundle for the filter-selection controller.
interface filter_switch_ctrl_if;
  import channel_strip_pkg::*;

  filt_sel_t filter_req;
  sample_t   filt_in;
  filt_sel_t filter;
  logic      filt_rst_n;
  sample_t   ch_out;
  logic      sample_tick;
  logic      busy;

  // The controller side.
  modport slave (
    input  filter_req, filt_in,
    output filter, filt_rst_n, ch_out, sample_tick, busy
  );

  // The side that drives requests and the raw filter output.
  modport master (
    output filter_req, filt_in,
    input  filter, filt_rst_n, ch_out, sample_tick, busy
  );

endinterface

// File: rtl/sample_phase_gen.sv
// Free-running clock-phase counter within one audio sample period.
// sample_tick marks the last clock of each period.
module sample_phase_gen #(
  parameter int PHASES = 3
) (
  input  logic clk_144,
  input  logic reset_n,
  output logic sample_tick
);

  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  logic [PW-1:0] phase;

  // Count 0..PHASES-1 and wrap.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    if (!reset_n) begin
      phase <= '0;
    end else if (phase == LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign sample_tick = (phase == LAST);

endmodule

// File: rtl/filter_switch_ctrl.sv
// Click-free filter selection: fade the filter output to zero, switch the
// select and clear the filter state for one sample, then fade back in.
module filter_switch_ctrl
  import channel_strip_pkg::*;
#(
  parameter int        PHASES    = CLKS_PER_SAMPLE,
  parameter int        RAMP_LOG  = 4,
  parameter filt_sel_t SEL_RESET = 3'd1
) (
  input logic                  clk_144,
  input logic                  reset_n,
  filter_switch_ctrl_if.slave  bus
);

  localparam int RAMP = 2 ** RAMP_LOG;
  localparam int GW   = RAMP_LOG + 1;
  localparam int PW   = $bits(sample_t) + GW + 1;

  typedef logic [GW-1:0] gain_t;
  localparam gain_t GAIN_FULL = gain_t'(RAMP);

  sw_state_t state, state_d;
  gain_t     gain, gain_d;
  filt_sel_t filter_q, filter_d;
  filt_sel_t pending, pending_d;
  logic      tick;
  logic      filt_rst_q;
  sample_t   ch_q;

  logic signed [PW-1:0] product;

  sample_phase_gen #(.PHASES(PHASES)) u_phase (
    .clk_144     (clk_144),
    .reset_n     (reset_n),
    .sample_tick (tick)
  );

  // Next-state, gain and select decisions; only evaluated on sample ticks.
  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_d   = state;
    gain_d    = gain;
    filter_d  = filter_q;
    pending_d = pending;
    if (tick) begin
      unique case (state)
        SW_IDLE: begin
          if (bus.filter_req != filter_q) begin
            pending_d = bus.filter_req;
            state_d   = SW_FADE_OUT;
          end
        end
        SW_FADE_OUT: begin
          // Latest request wins until the switch point.
          pending_d = bus.filter_req;
          if (gain != '0) gain_d = gain - 1'b1;
          if (gain <= gain_t'(1)) begin
            state_d  = SW_CLEAR;
            filter_d = pending_d;
          end
        end
        SW_CLEAR: begin
          state_d = SW_FADE_IN;
        end
        SW_FADE_IN: begin
          if (bus.filter_req != filter_q) begin
            // Reverse direction from the current gain, no jump.
            pending_d = bus.filter_req;
            state_d   = SW_FADE_OUT;
          end else begin
            gain_d = gain + 1'b1;
            if (gain_d == GAIN_FULL) state_d = SW_IDLE;
          end
        end
        default: state_d = SW_IDLE;
      endcase
    end
  end

  // Gain is never negative, so a zero-extended signed copy keeps the product exact.
  assign product = PW'(bus.filt_in) * PW'($signed({1'b0, gain}));

  // Controller registers plus the registered, gain-scaled output.
  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SW_IDLE;
      gain       <= GAIN_FULL;
      filter_q   <= SEL_RESET;
      pending    <= SEL_RESET;
      filt_rst_q <= 1'b0;
      ch_q       <= '0;
    end else begin
      state      <= state_d;
      gain       <= gain_d;
      filter_q   <= filter_d;
      pending    <= pending_d;
      filt_rst_q <= (state_d != SW_CLEAR);
      ch_q       <= sample_t'(product >>> RAMP_LOG);
    end
  end

  assign bus.filter      = filter_q;
  assign bus.filt_rst_n  = filt_rst_q;
  assign bus.ch_out      = ch_q;
  assign bus.sample_tick = tick;
  assign bus.busy        = (state != SW_IDLE);

endmodule

// File: tb/tb_filter_switch_ctrl.sv
// Self-checking bench for filter_switch_ctrl: a sample-level reference model
// compared every clock, plus directed scenarios with literal expectations.
module tb_filter_switch_ctrl;

  logic clk_144 = 1'b0;
  logic reset_n;

  filter_switch_ctrl_if bus ();

  filter_switch_ctrl dut (
    .clk_144 (clk_144),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk_144 = ~clk_144;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int floor16(input int p);
    if (p >= 0) return p / 16;
    return -((-p + 15) / 16);
  endfunction

  // ---------------- reference model (per sample, plain integers) ----------
  typedef enum {M_STEADY, M_DOWN, M_SWAP, M_UP} m_mode_t;
  m_mode_t            m_mode;
  int                 m_phase;
  int                 m_gain;
  logic [2:0]         m_filter;
  bit                 m_live;
  logic signed [15:0] m_ch;

  always @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_STEADY; m_phase <= 0; m_gain <= 16;
      m_filter <= 3'd1; m_live <= 1'b0; m_ch <= '0;
    end else begin
      m_live  <= 1'b1;
      m_ch    <= 16'(floor16(int'(bus.filt_in) * m_gain));
      m_phase <= (m_phase + 1) % 3;
      if (m_phase == 2) begin
        case (m_mode)
          M_STEADY: if (bus.filter_req != m_filter) m_mode <= M_DOWN;
          M_DOWN: begin
            m_gain <= (m_gain > 0) ? m_gain - 1 : 0;
            if (m_gain <= 1) begin
              m_mode   <= M_SWAP;
              m_filter <= bus.filter_req;
            end
          end
          M_SWAP: m_mode <= M_UP;
          M_UP: begin
            if (bus.filter_req != m_filter) m_mode <= M_DOWN;
            else begin
              m_gain <= m_gain + 1;
              if (m_gain + 1 == 16) m_mode <= M_STEADY;
            end
          end
        endcase
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk_144) begin
    if (cmp_en) begin
      check("cmp_filter", bus.filter, m_filter);
      check("cmp_filt_rst_n", bus.filt_rst_n, (m_live && m_mode != M_SWAP) ? 1 : 0);
      check("cmp_ch_out", bus.ch_out, m_ch);
      check("cmp_sample_tick", bus.sample_tick, (m_phase == 2) ? 1 : 0);
      check("cmp_busy", bus.busy, (m_mode != M_STEADY) ? 1 : 0);
    end
  end

  // Count filt_rst_n low pulses and their length in clocks (outside reset).
  int n_pulses = 0;
  int run_len  = 0;
  int last_len = 0;
  bit seen_two = 1'b0;
  always @(negedge clk_144) begin
    if (!reset_n) run_len = 0;
    else if (bus.filt_rst_n === 1'b0) run_len++;
    else if (run_len > 0) begin
      last_len = run_len;
      n_pulses++;
      run_len = 0;
    end
    if (bus.filter === 3'd2) seen_two = 1'b1;
  end

  // ---------------- stimulus helpers --------------------------------------
  // Returns #1 after the next tick (active) edge.
  task automatic next_tick_edge();
    int n = 0;
    @(negedge clk_144);
    while (bus.sample_tick !== 1'b1 && n < 6) begin
      @(negedge clk_144);
      n++;
    end
    if (bus.sample_tick !== 1'b1) check("tick_timeout", bus.sample_tick, 1);
    @(posedge clk_144);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int n = 0;
    @(negedge clk_144);
    while (bus.busy !== lvl && n < budget) begin
      @(negedge clk_144);
      n++;
    end
    check("busy_wait", bus.busy, lvl);
  endtask

  task automatic wait_frst(input logic lvl, input int budget);
    int n = 0;
    @(negedge clk_144);
    while (bus.filt_rst_n !== lvl && n < budget) begin
      @(negedge clk_144);
      n++;
    end
    check("filt_rst_wait", bus.filt_rst_n, lvl);
  endtask

  task automatic pulse_reset();
    @(posedge clk_144); #1;
    reset_n = 1'b0;
    bus.filter_req = 3'd1;
    repeat (2) @(negedge clk_144);
    #1 reset_n = 1'b1;
    @(posedge clk_144); #1;
  endtask

  // ---------------- directed scenarios ------------------------------------
  initial begin
    int p0;
    int busy_cycles;
    bus.filter_req = 3'd1;
    bus.filt_in    = 16'sd32767;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset values.
    repeat (3) @(negedge clk_144);
    check("rst_ch_out", bus.ch_out, 0);
    check("rst_filter", bus.filter, 1);
    check("rst_filt_rst_n", bus.filt_rst_n, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sample_tick", bus.sample_tick, 0);
    #1 reset_n = 1'b1;
    @(posedge clk_144); @(negedge clk_144);
    check("rel_filter", bus.filter, 1);
    check("rel_filt_rst_n", bus.filt_rst_n, 1);
    check("rel_ch_out", bus.ch_out, 32767);
    check("rel_busy", bus.busy, 0);

    // Switch 1 -> 2 with a negative full-scale input through the fade-out.
    @(posedge clk_144); #1;
    p0 = n_pulses;
    bus.filter_req = 3'd2;
    bus.filt_in    = -16'sd32767;
    wait_busy(1'b1, 10);
    check("sw12_filter_before", bus.filter, 1);
    for (int k = 1; k <= 16; k++) begin
      next_tick_edge();
      @(posedge clk_144); @(negedge clk_144);
      check("fade_out_ch", bus.ch_out, floor16(-32767 * (16 - k)));
      if (k == 1)  check("fade_out_g15", bus.ch_out, -30720);
      if (k == 16) check("fade_out_g0", bus.ch_out, 0);
    end
    check("sw12_filter_clear", bus.filter, 2);
    check("sw12_filt_rst_low", bus.filt_rst_n, 0);
    #1 bus.filt_in = 16'sd32767;
    wait_busy(1'b0, 150);
    repeat (2) @(negedge clk_144);
    check("sw12_ch_restored", bus.ch_out, 32767);
    check("sw12_pulses", n_pulses, p0 + 1);
    check("sw12_pulse_len", last_len, 3);

    // Request 2 then 3 during fade-out: one clear, filter 1 -> 3 directly.
    pulse_reset();
    seen_two = 1'b0;
    p0 = n_pulses;
    bus.filter_req = 3'd2;
    wait_busy(1'b1, 10);
    repeat (3) next_tick_edge();
    bus.filter_req = 3'd3;
    wait_busy(1'b0, 150);
    check("retarget_filter", bus.filter, 3);
    check("retarget_no_two", seen_two, 0);
    check("retarget_pulses", n_pulses, p0 + 1);

    // Request 4 during fade-in at gain 5: gain reverses 5, 4, 3 with no jump.
    @(posedge clk_144); #1;
    p0 = n_pulses;
    bus.filter_req = 3'd5;
    wait_busy(1'b1, 10);
    wait_frst(1'b0, 100);
    wait_frst(1'b1, 10);
    repeat (5) next_tick_edge();
    bus.filter_req = 3'd4;
    next_tick_edge();
    @(posedge clk_144); @(negedge clk_144);
    check("rev_gain5", bus.ch_out, 10239);
    next_tick_edge();
    @(posedge clk_144); @(negedge clk_144);
    check("rev_gain4", bus.ch_out, 8191);
    next_tick_edge();
    @(posedge clk_144); @(negedge clk_144);
    check("rev_gain3", bus.ch_out, 6143);
    check("rev_filter_mid", bus.filter, 5);
    wait_busy(1'b0, 200);
    check("rev_filter_final", bus.filter, 4);
    check("rev_pulses", n_pulses, p0 + 2);

    // Reset asserted at gain 8 during fade-out: immediate return, no clear after.
    @(posedge clk_144); #1;
    bus.filter_req = 3'd6;
    wait_busy(1'b1, 10);
    repeat (8) next_tick_edge();
    reset_n = 1'b0;
    bus.filter_req = 3'd1;
    #1;
    check("midrst_ch_out", bus.ch_out, 0);
    check("midrst_filter", bus.filter, 1);
    check("midrst_busy", bus.busy, 0);
    check("midrst_filt_rst_n", bus.filt_rst_n, 0);
    p0 = n_pulses;
    @(negedge clk_144);
    #1 reset_n = 1'b1;
    @(posedge clk_144); @(negedge clk_144);
    check("midrst_gain_full", bus.ch_out, 32767);
    busy_cycles = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_144);
      if (bus.busy !== 1'b0) busy_cycles++;
    end
    check("midrst_no_busy", busy_cycles, 0);
    check("midrst_no_clear", n_pulses, p0);
    check("midrst_filter_hold", bus.filter, 1);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/filter_switch_ctrl.md
# filter_switch_ctrl

Click-free filter-selection controller for the channel strip's filter path, clocked by `clk_144` (3 clocks per 48 kHz sample). It owns the `filter` select and the filter's state reset, and applies a linear gain ramp to the filter output around every change. On a new selection it fades out, switches and clears the filter at a sample boundary, then fades back in. It sits between the UI/control registers and the lowpass/filter datapath, and scales that datapath's output.

## Interface
- `PHASES`, 3, clocks per sample period.
- `RAMP_LOG`, 4, log2 of ramp length; `RAMP = 2**RAMP_LOG` samples.
- `SEL_RESET`, 3'd1, filter select value after reset.
- `clk_144`  in  1  system clock (144 kHz).
- `reset_n`  in  1  reset; asynchronous assert, active-low.
- `filter_req`  in  3  requested filter selection from control logic.
- `filt_in`  in  16 signed  raw filter output (the datapath's `lowpassOut`).
- `filter`  out  3  select driven to the filter datapath.
- `filt_rst_n`  out  1  active-low state clear to the filter datapath.
- `ch_out`  out  16 signed  gain-ramped filter output.
- `sample_tick`  out  1  high on the last clock of each sample period.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Phase counter: 0..PHASES-1, free-running, wraps to 0. `sample_tick` = (phase == PHASES-1). All state, gain and `filter_req` sampling happens only on tick cycles.
- Gain register: 0..RAMP (RAMP_LOG+1 bits). `ch_out` <= (filt_in * gain) >>> RAMP_LOG, registered every clock, arithmetic shift (truncation toward −inf). At gain = RAMP, `ch_out` equals `filt_in`.
- FSM states: IDLE, FADE_OUT, CLEAR, FADE_IN.
  - IDLE: on a tick where filter_req != filter, latch pending <= filter_req and go to FADE_OUT. Gain stays at RAMP.
  - FADE_OUT: on each tick, pending <= filter_req (last request wins) and gain <= gain−1, saturating at 0. When gain ≤ 1 on that tick, go to CLEAR.
  - CLEAR: on entry, filter <= pending. `filt_rst_n` = 0 for the whole state. Requests are ignored. Leave to FADE_IN on the next tick, so CLEAR lasts exactly one sample.
  - FADE_IN: on a tick where filter_req != filter, pending <= filter_req and go to FADE_OUT, keeping the current gain (no jump). Otherwise gain <= gain+1; when the new gain = RAMP, go to IDLE.
- `filt_rst_n` = 1 in all states except CLEAR.
- Reset values: phase 0, state IDLE, gain RAMP, filter = SEL_RESET, pending = SEL_RESET, filt_rst_n 0, ch_out 0, sample_tick 0, busy 0. The first clock after reset release drives filt_rst_n 1.
- Reset asserted mid-switch: everything returns immediately to the reset values, and the pending request is discarded.

## Timing
- `ch_out` latency: 1 clock from `filt_in` and from gain.
- Uninterrupted switch, starting from IDLE at RAMP = 16:
  - 1 detect tick;
  - 16 FADE_OUT ticks, with gain 15..0;
  - 1 CLEAR sample;
  - 16 FADE_IN ticks, with gain 1..16.
  - Total: 34 samples = 102 clocks from detect tick to IDLE.
- `filter` changes exactly once per completed switch, on the tick that enters CLEAR.
- `busy` rises the clock after the detect tick and falls the clock after the final FADE_IN tick.
- `filter_req` changes between ticks are invisible. A request equal to the current `filter` while in IDLE causes no action.

## Structure
- Shared package `channel_strip_pkg` holds:
  - the FSM state enum `sw_state_t`;
  - `sample_t` (logic signed [15:0]);
  - `filt_sel_t` (logic [2:0]);
  - constant `CLKS_PER_SAMPLE = 3`.
- One sub-module, `sample_phase_gen`, provides the phase counter and `sample_tick`. It is reusable by the other strip blocks.
- Gain multiply and shift stay inline.

## Test plan
- Reset, hold filter_req = 1, `filt_in` = 32767 → filter = 1, filt_rst_n = 1, ch_out = 32767 one clock after reset release, busy = 0.
- filter_req 1→2 → busy rises; on the final FADE_OUT tick (gain 0) ch_out = 0; filter = 2 with filt_rst_n low for exactly 3 clocks; IDLE after 102 clocks; ch_out back to 32767.
- `filt_in` = −32767, sample ch_out at each FADE_OUT tick → ch_out = floor(−32767·g/16) for g = 15..0, e.g. g = 15 → −30720.
- Request 2, then 3 during FADE_OUT → no CLEAR for 2; filter goes 1→3 directly; only one CLEAR pulse.
- Request 4 while in FADE_IN at gain 5 → gain continues 4, 3, … with no jump; filter then becomes 4.
- Assert reset_n at gain 8 in FADE_OUT → ch_out = 0, filter = 1, gain = 16 immediately; no CLEAR follows release.
